// File: rtl/microstore_seq.sv
// Writable control store with registered read-out.
// Holds the microprogram (NUM_STATES words of WORD_W bits), sequences through
// it under control of the next-state logic, and halts on an out-of-range state.
module microstore_seq #(
  parameter int NUM_STATES  = 257,
  parameter int WORD_W      = 44,
  parameter int STATE_W     = 10,
  parameter int RESET_STATE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic [STATE_W-1:0] next_state,
  input  logic               wr_en,
  input  logic [STATE_W-1:0] wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  output logic [WORD_W-1:0]  out,
  output logic [STATE_W-1:0] current_state,
  output logic               running,
  output logic               halted
);

  localparam int               IDX_W  = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [STATE_W:0] LIMIT  = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] RST_ST = STATE_W'(RESET_STATE);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_out;
  logic [STATE_W-1:0]  r_cur;
  logic                r_running;
  logic                r_halted;
  logic [WORD_W-1:0]   r_mem [NUM_STATES];

  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_rd_hit;
  logic [STATE_W-1:0]  w_rd_addr;
  logic [WORD_W-1:0]   w_rd_word;

  // Read port: the word that would be loaded on this edge, write-first on a hit.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_wr_ok   = wr_en && ({1'b0, wr_addr} < LIMIT);
    w_rd_addr = (r_state == S_LOAD) ? RST_ST : next_state;
    w_rd_ok   = ({1'b0, w_rd_addr} < LIMIT);
    w_rd_hit  = w_wr_ok && (wr_addr == w_rd_addr);
    w_rd_word = '0;
    if (w_rd_hit) begin
      w_rd_word = wr_data;
    end else if (w_rd_ok) begin
      w_rd_word = r_mem[w_rd_addr[IDX_W-1:0]];
    end
  end

  // Control-store write port; out-of-range addresses are dropped.
  // NOTE: the array has no reset so microcode survives a reset and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Sequencer FSM with registered control word, state number and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_LOAD;
      r_out     <= '0;
      r_cur     <= '0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (start) begin
            r_state   <= S_RUN;
            r_cur     <= RST_ST;
            r_out     <= w_rd_word;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (advance) begin
            r_cur <= next_state;
            if (w_rd_ok) begin
              r_out <= w_rd_word;
            end else begin
              r_state   <= S_HALT;
              r_out     <= '0;
              r_running <= 1'b0;
              r_halted  <= 1'b1;
            end
          end
        end
        S_HALT: begin
          r_out <= '0;
        end
        default: begin
          r_state   <= S_LOAD;
          r_out     <= '0;
          r_cur     <= '0;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  assign out           = r_out;
  assign current_state = r_cur;
  assign running       = r_running;
  assign halted        = r_halted;

endmodule

// File: tb/tb_microstore_seq.sv
// Self-checking bench for microstore_seq: a behavioural control-store model
// checked every cycle, plus literal expectations from the directed scenarios.
module tb_microstore_seq;

  localparam int NS = 257;
  localparam int WW = 44;
  localparam int SW = 10;

  localparam logic [WW-1:0] W0   = 44'h21000663400;
  localparam logic [WW-1:0] W1   = 44'h60402024000;
  localparam logic [WW-1:0] W2   = 44'h0F0F0F0F0F0;
  localparam logic [WW-1:0] W256 = 44'hF00000000A5;

  logic          clk;
  logic          reset;
  logic          start;
  logic          advance;
  logic [SW-1:0] next_state;
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [WW-1:0] out;
  logic [SW-1:0] current_state;
  logic          running;
  logic          halted;

  int n_cmp = 0;
  int n_bad = 0;

  microstore_seq #(
    .NUM_STATES (NS),
    .WORD_W     (WW),
    .STATE_W    (SW),
    .RESET_STATE(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .advance      (advance),
    .next_state   (next_state),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .out          (out),
    .current_state(current_state),
    .running      (running),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_LOAD, M_RUN, M_HALT} mode_t;
  mode_t         m_mode = M_LOAD;
  logic [WW-1:0] m_out  = '0;
  logic [SW-1:0] m_cur  = '0;
  logic [WW-1:0] m_mem [1024];
  logic          m_wr_ok;

  // Word seen by a read on this edge: a same-edge legal write wins.
  function automatic logic [WW-1:0] m_rd(input logic [SW-1:0] a);
    if (m_wr_ok && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_LOAD;
      m_out  = '0;
      m_cur  = '0;
    end else begin
      m_wr_ok = wr_en && (int'(wr_addr) < NS);
      if (m_mode == M_LOAD && start) begin
        m_mode = M_RUN;
        m_cur  = '0;
        m_out  = m_rd('0);
      end else if (m_mode == M_RUN && advance) begin
        m_cur = next_state;
        if (int'(next_state) < NS) begin
          m_out = m_rd(next_state);
        end else begin
          m_mode = M_HALT;
          m_out  = '0;
        end
      end
      if (m_wr_ok) m_mem[wr_addr] = wr_data;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_out",     64'(out),           64'(m_out));
    check("cyc_state",   64'(current_state), 64'(m_cur));
    check("cyc_running", 64'(running),       64'(m_mode == M_RUN));
    check("cyc_halted",  64'(halted),        64'(m_mode == M_HALT));
  end

  // ---------------- stimulus ----------------
  // Called just after an active edge; holds inputs over one edge, then idles them.
  task automatic cyc(input logic st, input logic adv, input int ns,
                     input logic we, input int wa, input logic [WW-1:0] wd);
    start      = st;
    advance    = adv;
    next_state = SW'(ns);
    wr_en      = we;
    wr_addr    = SW'(wa);
    wr_data    = wd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    advance = 1'b0;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    advance    = 1'b0;
    next_state = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",     64'(out),           64'h0);
    check("rst_state",   64'(current_state), 64'h0);
    check("rst_running", 64'(running),       64'h0);
    check("rst_halted",  64'(halted),        64'h0);
    reset = 1'b1;

    // LOAD: fill words; advance must be ignored.
    cyc(0, 0, 0, 1, 0, W0);
    cyc(0, 1, 1, 1, 1, W1);
    check("load_adv_ignored_out", 64'(out),     64'h0);
    check("load_running",         64'(running), 64'h0);
    cyc(0, 0, 0, 1, 2, W2);
    cyc(0, 0, 0, 1, 256, W256);

    // Start: first word one edge later.
    cyc(1, 0, 0, 0, 0, '0);
    check("start_out",     64'(out),           64'(W0));
    check("start_state",   64'(current_state), 64'h0);
    check("start_running", 64'(running),       64'h1);

    cyc(0, 1, 1, 0, 0, '0);
    check("adv1_out", 64'(out), 64'(W1));

    // Hold with junk next_state.
    for (int i = 0; i < 5; i++) cyc(0, 0, i + 5, 0, 0, '0);
    check("hold_out",   64'(out),           64'(W1));
    check("hold_state", 64'(current_state), 64'h1);

    // Write-first bypass, then re-entry.
    cyc(0, 1, 3, 1, 3, 44'hABC);
    check("bypass_out",   64'(out),           64'hABC);
    check("bypass_state", 64'(current_state), 64'h3);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 1, 3, 0, 0, '0);
    check("reenter3_out", 64'(out), 64'hABC);

    // Writing the current word does not disturb out until re-entry.
    cyc(0, 0, 0, 1, 3, 44'h123);
    check("wr_cur_hold", 64'(out), 64'hABC);
    cyc(0, 1, 1, 0, 0, '0);
    cyc(0, 1, 3, 0, 0, '0);
    check("wr_cur_reenter", 64'(out), 64'h123);

    // start ignored in RUN.
    cyc(1, 0, 0, 0, 0, '0);
    check("run_start_ignored", 64'(out), 64'h123);

    // Dropped write beyond the array: no halt, contents intact.
    cyc(0, 0, 0, 1, 300, 44'hDEAD);
    check("drop_halted",  64'(halted),  64'h0);
    check("drop_running", 64'(running), 64'h1);
    cyc(0, 1, 0, 0, 0, '0);   check("seq0",   64'(out), 64'(W0));
    cyc(0, 1, 1, 0, 0, '0);   check("seq1",   64'(out), 64'(W1));
    cyc(0, 1, 2, 0, 0, '0);   check("seq2",   64'(out), 64'(W2));
    cyc(0, 1, 3, 0, 0, '0);   check("seq3",   64'(out), 64'h123);
    cyc(0, 1, 256, 0, 0, '0); check("seq256", 64'(out), 64'(W256));

    // Out of range: halt and freeze.
    cyc(0, 1, 257, 0, 0, '0);
    check("halt_flag",    64'(halted),        64'h1);
    check("halt_out",     64'(out),           64'h0);
    check("halt_state",   64'(current_state), 64'd257);
    check("halt_running", 64'(running),       64'h0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, '0);
    check("halt_frozen_state", 64'(current_state), 64'd257);
    cyc(0, 0, 0, 1, 2, 44'h777);   // write accepted while halted

    // Reset leaves the array; start with a bypass write to RESET_STATE.
    do_reset();
    cyc(1, 0, 0, 1, 0, 44'h5A5A);
    check("start_bypass_out", 64'(out),     64'h5A5A);
    check("start_bypass_run", 64'(running), 64'h1);
    cyc(0, 1, 2, 0, 0, '0);
    check("halt_write_kept", 64'(out), 64'h777);
    cyc(0, 1, 1, 0, 0, '0);
    check("array_kept", 64'(out), 64'(W1));

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async_out",     64'(out),           64'h0);
    check("async_state",   64'(current_state), 64'h0);
    check("async_running", 64'(running),       64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 1, 1, 0, 0, '0);
    check("post_rst_load_out", 64'(out),     64'h0);
    check("post_rst_load_run", 64'(running), 64'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
